// File: rtl/i2c_reg_read_seq_if.sv
// ---------------------------------------------------------------------------
// i2c_reg_read_seq_if
//
// Slot bus between the register-read sequencer (master) and the I2C MMIO
// slot core (slave).
//
// Signals:
//   io_cs       chip select for the slot
//   io_read     read strobe (status poll)
//   io_write    write strobe (divisor / command)
//   io_addr     1 = divisor register, 2 = command register, 0 = status read
//   io_wr_data  [10:8] = cmd (START 0, WR 1, RD 2, STOP 3, RESTART 4), [7:0] = din
//   io_rd_data  combinational status: [9] = ack (0 = slave acked),
//               [8] = ready, [7:0] = received byte
//
// Handshake: there is no valid/ready pair on this bus. A write is a single
// cycle with io_cs = io_write = 1. A read is any cycle with
// io_cs = io_read = 1, and io_rd_data is sampled in that same cycle.
// ---------------------------------------------------------------------------
interface i2c_reg_read_seq_if;
    logic        io_cs;
    logic        io_read;
    logic        io_write;
    logic [4:0]  io_addr;
    logic [31:0] io_wr_data;
    logic [31:0] io_rd_data;

    modport master (
        output io_cs,
        output io_read,
        output io_write,
        output io_addr,
        output io_wr_data,
        input  io_rd_data
    );

    modport slave (
        input  io_cs,
        input  io_read,
        input  io_write,
        input  io_addr,
        input  io_wr_data,
        output io_rd_data
    );
endinterface

// File: rtl/i2c_reg_read_seq.sv
// ---------------------------------------------------------------------------
// i2c_reg_read_seq
//
// Runs one complete I2C register read for each accepted start pulse:
//   START, WR {dev,0}, WR reg, RESTART, WR {dev,1}, RD x (rd_len+1), STOP.
// It drives the I2C core slot bus as a master. It returns the bytes packed
// little-endian in rd_bytes, together with err and a done pulse.
//
// Optional feature: define I2C_SEQ_TIMEOUT_EN to add a poll watchdog.
// After TIMEOUT_CYCLES cycles in POLL without ready, the sequencer ends the
// transaction with err = 2 and does not issue a STOP.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   start           one-cycle request, accepted only while busy = 0
//   dev_addr[6:0]   slave address, latched on an accepted start
//   reg_addr[7:0]   register pointer, latched on an accepted start
//   rd_len[1:0]     byte count minus 1, latched on an accepted start
//   busy            high through INIT, and from an accepted start through DONE
//   done            one-cycle pulse at the end of each transaction
//   err[1:0]        0 ok, 1 NACK, 2 timeout
//   rd_bytes[31:0]  first byte in [7:0]; bytes not read stay 0
//   dbg_state[2:0]  current FSM state, for observation
//   io              slot bus (master side)
// ---------------------------------------------------------------------------
module i2c_reg_read_seq #(
    parameter logic [15:0] DVSR           = 16'd250,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [6:0]                dev_addr,
    input  logic [7:0]                reg_addr,
    input  logic [1:0]                rd_len,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                err,
    output logic [31:0]               rd_bytes,
    output logic [2:0]                dbg_state,
    i2c_reg_read_seq_if.master        io
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_POLL   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        STEP_START     = 3'd0,
        STEP_WR_DEV_W  = 3'd1,
        STEP_WR_REG    = 3'd2,
        STEP_RESTART   = 3'd3,
        STEP_WR_DEV_R  = 3'd4,
        STEP_RD        = 3'd5,
        STEP_STOP      = 3'd6
    } step_e;

    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_WR      = 3'd1;
    localparam logic [2:0] CMD_RD      = 3'd2;
    localparam logic [2:0] CMD_STOP    = 3'd3;
    localparam logic [2:0] CMD_RESTART = 3'd4;

    // A zero watchdog limit cannot be used. Referencing the parameter here
    // also keeps it elaborated in builds where the watchdog is absent.
    if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout_unsupported
    end

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic [1:0]  rd_cnt_q, rd_cnt_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [1:0]  len_q, len_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rd_bytes_q, rd_bytes_d;
`ifdef I2C_SEQ_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Combinational strobes. They are gated by reset_n afterwards so that an
    // asserted reset forces every output low immediately.
    logic        cs_c, rd_c, wr_c, busy_c, done_c;
    logic [4:0]  addr_c;
    logic [31:0] wdata_c;

    // Status fields taken from the core
    logic [31:0] status;
    logic        st_ack, st_ready;
    logic [7:0]  st_byte;
    logic        unused_status;

    assign status        = io.io_rd_data;
    assign st_ack        = status[9];
    assign st_ready      = status[8];
    assign st_byte       = status[7:0];
    assign unused_status = ^status[31:10];

    // Command word for the current step
    logic [2:0] step_cmd;
    logic [7:0] step_din;
    logic       step_is_wr;
    logic       last_rd;

    assign last_rd = (rd_cnt_q == len_q);

    always_comb begin
        step_cmd   = CMD_START;
        step_din   = 8'h00;
        step_is_wr = 1'b0;
        case (step_q)
            STEP_START:    step_cmd = CMD_START;
            STEP_WR_DEV_W: begin
                step_cmd   = CMD_WR;
                step_din   = {dev_q, 1'b0};
                step_is_wr = 1'b1;
            end
            STEP_WR_REG:   begin
                step_cmd   = CMD_WR;
                step_din   = reg_q;
                step_is_wr = 1'b1;
            end
            STEP_RESTART:  step_cmd = CMD_RESTART;
            STEP_WR_DEV_R: begin
                step_cmd   = CMD_WR;
                step_din   = {dev_q, 1'b1};
                step_is_wr = 1'b1;
            end
            // The master ACKs every byte except the last one, which it NACKs.
            STEP_RD:       begin
                step_cmd = CMD_RD;
                step_din = {7'b0, last_rd};
            end
            STEP_STOP:     step_cmd = CMD_STOP;
            default:       step_cmd = CMD_STOP;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        rd_cnt_d   = rd_cnt_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        len_d      = len_q;
        err_d      = err_q;
        rd_bytes_d = rd_bytes_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        cs_c    = 1'b0;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        addr_c  = 5'd0;
        wdata_c = 32'd0;
        busy_c  = 1'b1;
        done_c  = 1'b0;

        case (state_q)
            ST_INIT: begin
                cs_c    = 1'b1;
                wr_c    = 1'b1;
                addr_c  = 5'd1;
                wdata_c = {16'd0, DVSR};
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                busy_c = 1'b0;
                if (start) begin
                    dev_d      = dev_addr;
                    reg_d      = reg_addr;
                    len_d      = rd_len;
                    err_d      = 2'd0;
                    rd_bytes_d = 32'd0;
                    step_d     = STEP_START;
                    rd_cnt_d   = 2'd0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cs_c    = 1'b1;
                wr_c    = 1'b1;
                addr_c  = 5'd2;
                wdata_c = {21'd0, step_cmd, step_din};
`ifdef I2C_SEQ_TIMEOUT_EN
                tmo_cnt_d = 32'd0;
`endif
                state_d = ST_SETTLE;
            end
            // The core needs one cycle to drop ready after a command write.
            ST_SETTLE: state_d = ST_POLL;
            ST_POLL: begin
                cs_c = 1'b1;
                rd_c = 1'b1;
                if (st_ready) begin
                    if (step_q == STEP_STOP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        if (step_is_wr && st_ack) begin
                            // A NACK on any address/pointer write ends the
                            // transfer with a STOP.
                            err_d  = 2'd1;
                            step_d = STEP_STOP;
                        end else if (step_q == STEP_RD) begin
                            rd_bytes_d[{rd_cnt_q, 3'b000} +: 8] = st_byte;
                            if (last_rd) begin
                                step_d = STEP_STOP;
                            end else begin
                                rd_cnt_d = rd_cnt_q + 2'd1;
                            end
                        end else begin
                            step_d = step_e'(step_q + 3'd1);
                        end
                    end
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q >= TIMEOUT_CYCLES - 1) begin
                    // The core is stuck, so no STOP is attempted.
                    err_d   = 2'd2;
                    state_d = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
`endif
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            step_q     <= STEP_START;
            rd_cnt_q   <= 2'd0;
            dev_q      <= 7'd0;
            reg_q      <= 8'd0;
            len_q      <= 2'd0;
            err_q      <= 2'd0;
            rd_bytes_q <= 32'd0;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_cnt_q  <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            rd_cnt_q   <= rd_cnt_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            len_q      <= len_d;
            err_q      <= err_d;
            rd_bytes_q <= rd_bytes_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    // The state register resets to INIT, but while reset is held, busy and
    // the INIT strobes must read 0.
    assign busy          = reset_n & busy_c;
    assign done          = reset_n & done_c;
    assign io.io_cs      = reset_n & cs_c;
    assign io.io_read    = reset_n & rd_c;
    assign io.io_write   = reset_n & wr_c;
    assign io.io_addr    = reset_n ? addr_c : 5'd0;
    assign io.io_wr_data = reset_n ? wdata_c : 32'd0;
    assign err           = err_q;
    assign rd_bytes      = rd_bytes_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_i2c_reg_read_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_read_seq
//
// Self-checking bench for i2c_reg_read_seq. A behavioural I2C core model
// answers the slot bus with random wait states, scripted NACKs and random
// data. Each transaction's expected command stream, data word and error code
// come from the transaction description alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_reg_read_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        start;
    logic [6:0]  dev_addr;
    logic [7:0]  reg_addr;
    logic [1:0]  rd_len;
    logic        busy, done;
    logic [1:0]  err;
    logic [31:0] rd_bytes;
    logic [2:0]  dbg_state;

    i2c_reg_read_seq_if io_if();

    i2c_reg_read_seq #(
        .DVSR           (16'd250),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .rd_len    (rd_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_bytes  (rd_bytes),
        .dbg_state (dbg_state),
        .io        (io_if)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cmdw(input logic [2:0] cmd, input logic [7:0] din);
        return {21'd0, cmd, din};
    endfunction

    // ---------------- I2C core model ----------------
    logic [7:0] rx_tab[4];
    int         max_wait = 0;
    int         nack_at  = 0;   // 1-based index of the WR to NACK, 0 = none
    bit         hang     = 1'b0;
    int         wr_idx   = 0;
    int         rd_idx   = 0;
    int         wait_cnt = 0;
    logic       ack_m    = 1'b0;
    logic [7:0] rx_m     = 8'h00;
    int         dvsr_cnt = 0;

    assign io_if.io_rd_data = {22'd0, ack_m, (!hang && wait_cnt == 0), rx_m};

    always @(negedge clk) begin
        logic [31:0] exp;
        if (reset_n && io_if.io_cs && io_if.io_write) begin
            if (io_if.io_addr == 5'd1) begin
                dvsr_cnt++;
                check_eq("dvsr_data", io_if.io_wr_data, 32'd250);
            end else begin
                check_eq("cmd_addr", {27'd0, io_if.io_addr}, 32'd2);
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check_eq("cmd", io_if.io_wr_data, exp);
                ack_m = 1'b0;
                if (io_if.io_wr_data[10:8] == 3'd1) begin
                    wr_idx++;
                    ack_m = (wr_idx == nack_at);
                end
                if (io_if.io_wr_data[10:8] == 3'd2) begin
                    rx_m = (rd_idx < 4) ? rx_tab[rd_idx] : 8'hEE;
                    rd_idx++;
                end
                wait_cnt = $urandom_range(max_wait, 0);
            end
        end else if (wait_cnt > 0) begin
            wait_cnt--;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic release_reset();
        dvsr_cnt = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("init_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        check_eq("dvsr_writes", dvsr_cnt, 32'd1);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_strobes", {29'd0, io_if.io_cs, io_if.io_read, io_if.io_write}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {29'd0, busy, done, err}, 32'd0);
        check_eq({tag, "_data"}, rd_bytes | io_if.io_wr_data, 32'd0);
        check_eq({tag, "_bus"}, {24'd0, io_if.io_cs, io_if.io_read, io_if.io_write, io_if.io_addr}, 32'd0);
    endtask

    // Builds the expected command stream and result, then runs one
    // transaction to done.
    task automatic do_txn(input logic [6:0] dev, input logic [7:0] rg, input int len,
                          input int nack, input int wmax, input bit poke, input bit hang_i,
                          input int lat_lo, input int lat_hi);
        logic [10:0] seq[$];
        logic [31:0] exp_bytes;
        logic [1:0]  exp_err;
        int          wr;
        int          cyc;

        exp_q.delete();
        exp_bytes = 32'd0;
        exp_err   = 2'd0;
        if (hang_i) begin
            exp_q.push_back(cmdw(3'd0, 8'h00));
            exp_err = 2'd2;
        end else begin
            seq.push_back({3'd0, 8'h00});
            seq.push_back({3'd1, dev, 1'b0});
            seq.push_back({3'd1, rg});
            seq.push_back({3'd4, 8'h00});
            seq.push_back({3'd1, dev, 1'b1});
            for (int k = 0; k <= len; k++) seq.push_back({3'd2, 7'd0, (k == len)});
            seq.push_back({3'd3, 8'h00});
            wr = 0;
            foreach (seq[i]) begin
                exp_q.push_back({21'd0, seq[i]});
                if (seq[i][10:8] == 3'd1) begin
                    wr++;
                    if (wr == nack) begin
                        exp_err = 2'd1;
                        exp_q.push_back(cmdw(3'd3, 8'h00));
                        break;
                    end
                end
            end
            if (exp_err == 2'd0)
                for (int k = 0; k <= len; k++) exp_bytes[8*k +: 8] = rx_tab[k];
        end

        max_wait = wmax;
        nack_at  = nack;
        hang     = hang_i;
        wr_idx   = 0;
        rd_idx   = 0;

        @(negedge clk);
        dev_addr = dev;
        reg_addr = rg;
        rd_len   = len[1:0];
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 5) begin
                dev_addr = 7'h50;
                reg_addr = 8'hA5;
                rd_len   = 2'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("done_seen", {31'd0, done}, 32'd1);
        if (lat_lo >= 0)
            check_eq("latency", {31'd0, (cyc >= lat_lo && cyc <= lat_hi)}, 32'd1);
        check_eq("err", {30'd0, err}, {30'd0, exp_err});
        check_eq("rd_bytes", rd_bytes, exp_bytes);
        check_eq("cmds_left", exp_q.size(), 32'd0);
        check_eq("busy_in_done", {31'd0, busy}, 32'd1);
        hang = 1'b0;
        // A start coincident with done must not be taken.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("post_done", {30'd0, busy, done}, 32'd0);
        check_eq("err_hold", {30'd0, err}, {30'd0, exp_err});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        dev_addr = 7'd0;
        reg_addr = 8'd0;
        rd_len   = 2'd0;
        foreach (rx_tab[i]) rx_tab[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        release_reset();

        // 1-byte read, zero-wait core
        rx_tab[0] = 8'h2A;
        do_txn(7'h1D, 8'h0F, 0, 0, 0, 1'b0, 1'b0, 22, 22);

        // 4-byte read
        rx_tab[0] = 8'h11; rx_tab[1] = 8'h22; rx_tab[2] = 8'h33; rx_tab[3] = 8'h44;
        do_txn(7'h1D, 8'h0F, 3, 0, 2, 1'b0, 1'b0, -1, -1);

        // NACK on the device-address write
        do_txn(7'h22, 8'h10, 2, 1, 1, 1'b0, 1'b0, -1, -1);

        // start while busy is ignored
        rx_tab[0] = 8'h5C; rx_tab[1] = 8'h6D;
        do_txn(7'h3C, 8'h40, 1, 0, 3, 1'b1, 1'b0, -1, -1);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Stuck core: the watchdog fires about 50 cycles after POLL starts.
        do_txn(7'h10, 8'h01, 0, 0, 0, 1'b0, 1'b1, 50, 58);
`endif

        // Reset during POLL
        exp_q.delete();
        exp_q.push_back(cmdw(3'd0, 8'h00));
        hang = 1'b1;
        @(negedge clk);
        dev_addr = 7'h12;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("in_poll_read", {31'd0, io_if.io_read}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_poll");
        check_eq("cmds_before_reset", exp_q.size(), 32'd0);
        hang = 1'b0;
        wait_cnt = 0;
        release_reset();

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            int len, nack;
            foreach (rx_tab[i]) rx_tab[i] = 8'($urandom_range(255, 0));
            len  = $urandom_range(3, 0);
            nack = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0;
            do_txn(7'($urandom_range(127, 0)), 8'($urandom_range(255, 0)), len, nack,
                   $urandom_range(4, 0), 1'($urandom_range(1, 0)), 1'b0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/i2c_reg_read_seq.md
# i2c_reg_read_seq

Hardware sequencer that sits directly upstream of the I2C MMIO slot core and drives its slot interface as a bus master. It performs one complete I2C register read on a single `start` pulse: START, device address with write, register address, RESTART, device address with read, 1–4 data bytes, STOP. It frees the processor from polling the I2C core byte by byte and returns the bytes packed into one word with done and error status.

## Interface
- `DVSR`, default 16'd250: SCL divisor written to the core once after reset.
- `TIMEOUT_CYCLES`, default 100000: poll watchdog limit; used only when `I2C_SEQ_TIMEOUT_EN` is defined.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; ignored unless `busy`=0.
- `dev_addr` in 7: 7-bit slave address; sampled on an accepted `start`.
- `reg_addr` in 8: register pointer; sampled on an accepted `start`.
- `rd_len` in 2: byte count minus 1 (0 means 1 byte, 3 means 4 bytes); sampled on an accepted `start`.
- `busy` out 1: high from reset release through INIT, and from an accepted `start` through DONE.
- `done` out 1: one-cycle pulse at the end of every transaction.
- `err` out 2: 0 = ok, 1 = NACK, 2 = timeout; valid from `done` until the next accepted `start`.
- `rd_bytes` out 32: the first byte read is in [7:0], the next in [15:8], and so on; unread bytes are 0.
- `io_cs`, `io_read`, `io_write` out 1 each: slot strobes toward the I2C core.
- `io_addr` out 5: 1 = divisor register, 2 = command register, 0 = status read.
- `io_wr_data` out 32: [10:8] = cmd (START 0, WR 1, RD 2, STOP 3, RESTART 4), [7:0] = din.
- `io_rd_data` in 32: combinational status from the core; [9] = ack (0 means slave acked), [8] = ready, [7:0] = received byte.

## Operation
- States: INIT, IDLE, ISSUE, SETTLE, POLL, DONE.
- **INIT** (first cycle after reset release): write `DVSR` to address 1, then go to IDLE.
- **IDLE:** on `start`, latch the inputs, clear `rd_bytes` and `err`, set step index 0, go to ISSUE.
- **ISSUE:** write one step for exactly one cycle with `io_cs`=`io_write`=1, then go to SETTLE.
- **SETTLE:** one idle cycle so the core can drop `ready`. Then go to POLL.
- **POLL:** hold `io_cs`=`io_read`=1 with `io_addr`=0. Sample `io_rd_data` in the same cycle. Stay in POLL while ready=0.
- When ready=1 in POLL:
  - If the step was a WR and ack=1: set `err`=1 and force the next step to STOP.
  - If the step was a RD: store byte[7:0] into lane k.
  - If the completed step was STOP, go to DONE; otherwise advance the step and go to ISSUE.
- Step list:
  1. START
  2. WR {dev_addr, 0}
  3. WR reg_addr
  4. RESTART
  5. WR {dev_addr, 1}
  6. RD × (rd_len+1): din[0]=0 (master ACK) on every byte except the last, which uses din[0]=1 (NACK).
  7. STOP
- **DONE:** pulse `done` for one cycle, deassert `busy`, return to IDLE.
- On error, `rd_bytes` keeps any bytes already read.

## Timing
- Reset values: `busy`=0 while `reset_n` is low, then 1 in INIT; all other outputs 0.
- Minimum cost per step: 3 cycles (ISSUE, SETTLE, one POLL) plus the core's busy time.
- Latency with an always-ready core and `rd_len`=0: 7 steps × 3 cycles + 1 for DONE = 22 cycles from `start` to `done`.
- `start` in the same cycle as `done` is ignored.
- `start` while `busy`=1 is ignored, and the latched inputs do not change.
- `reset_n` asserted mid-transaction: all outputs go to 0 immediately. No STOP is issued; the bus is recovered by the STOP of the next transaction.

## Configuration
- `I2C_SEQ_TIMEOUT_EN` defined:
  - A counter runs in POLL and clears on each ISSUE.
  - When it reaches `TIMEOUT_CYCLES`, set `err`=2 and go directly to DONE, with no STOP.
- `I2C_SEQ_TIMEOUT_EN` undefined: no counter exists; POLL waits indefinitely and `err` is never 2.

## Test plan
- **After reset:** expect exactly one write to addr 1 with data 250, then `busy`=0 and all io strobes 0.
- **Successful 1-byte read:** dev 0x1D, reg 0x0F, `rd_len`=0, slave model returns 0x2A → command sequence 0x000, 0x13A, 0x10F, 0x400, 0x13B, 0x201, 0x300; `rd_bytes`=0x0000002A; `err`=0; `done` 22 cycles after `start` with a zero-wait core.
- **4-byte read:** `rd_len`=3, bytes 0x11, 0x22, 0x33, 0x44 → RD din values 0, 0, 0, 1; `rd_bytes`=0x44332211.
- **Device-address NACK:** ack=1 on the first WR → next command is 0x300 (STOP); `err`=1; `rd_bytes`=0; no RD issued.
- **`start` while busy:** second `start` with dev 0x50 mid-transfer → ignored; bus traffic still uses the first `dev_addr`.
- **Timeout (with macro, `TIMEOUT_CYCLES`=50):** ready held at 0 → `done` with `err`=2 about 50 cycles after entering POLL.
- **Reset mid-POLL:** assert `reset_n` low during POLL → all outputs 0 at once; normal INIT follows release.
